// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared FSM state encoding and the load value returned on a bus timeout.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RDONE = 2'd3
    } state_t;

    localparam logic [31:0] POISON = 32'h0;

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted-write buffer (address, data, valid flag).
// Ports: clk, reset (async, active-low), load (capture load_addr/load_data),
//        clear (drop the entry), valid/addr/data (current entry).
// A load in the same cycle as a clear wins, so a new store can refill the
// entry on the very edge its predecessor is acknowledged.
module dmem_wbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU data-memory port to single-cycle-ack system bus, with a posted-write buffer.
// Ports: clk, reset (async, active-low); CPU side cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//        cpu_rdata/cpu_stall/cpu_err out; bus side bus_req/bus_we/bus_addr/bus_wdata out,
//        bus_ack/bus_rdata in.
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to abort a bus access after
// TIMEOUT_CYCLES unacknowledged cycles (write discarded, load returns POISON).
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state;
    logic [31:0] rd_addr;
    logic        wb_valid;
    logic [31:0] wb_addr;
    logic        aligned;
    logic        ack;
    logic        to;
    logic        active;
    logic        buf_free;
    logic        accept;
    logic        load_req;
    logic        wr_end;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    // In READ/RDONE the CPU is still presenting the load being served, so new
    // requests are only decoded in IDLE and WRITE.
    assign aligned  = cpu_addr[1:0] == 2'b00;
    assign ack      = bus_req && bus_ack;
    assign active   = state == IDLE || state == WRITE;
    assign buf_free = !wb_valid || (state == WRITE && ack);
    assign accept   = active && cpu_req && cpu_we && aligned && buf_free;
    assign load_req = active && cpu_req && !cpu_we && aligned;
    assign wr_end   = state == WRITE && (ack || to);

    assign cpu_stall = cpu_req && aligned && (state == READ || (active && !(cpu_we && buf_free)));
    assign bus_req   = state == WRITE || state == READ;
    assign bus_we    = state == WRITE;
    assign bus_addr  = state == WRITE ? wb_addr : rd_addr;

    dmem_wbuf u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .clear     (wr_end),
        .load_addr (cpu_addr),
        .load_data (cpu_wdata),
        .valid     (wb_valid),
        .addr      (wb_addr),
        .data      (bus_wdata)
    );

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [31:0] tcnt;

    assign to = bus_req && !bus_ack && tcnt == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else
            tcnt <= (bus_req && !bus_ack && !to) ? tcnt + 32'd1 : '0;
    end
`else
    assign to = 1'b0;
`endif

    // A write that is acked while another store waits goes straight back to
    // WRITE with the new entry, keeping bus_req high across the handover.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_err <= (active && cpu_req && !aligned) || to;
            case (state)
                IDLE:    state <= accept ? WRITE : load_req ? READ : IDLE;
                WRITE:   state <= accept ? WRITE : wr_end ? IDLE : WRITE;
                READ:    state <= (ack || to) ? RDONE : READ;
                default: state <= IDLE;
            endcase
            if (state == IDLE && load_req)
                rd_addr <= {cpu_addr[31:2], 2'b00};
            if (state == READ && (ack || to))
                cpu_rdata <= ack ? bus_rdata : POISON;
        end
    end

endmodule
